ifu: RTL and testbench
======================

IFU -- requirements
Module: ifu

Interface
REQ-001 Parameter RESET_VECTOR, default 32'h0000_0000, the first fetch address after reset.
REQ-002 Parameter FB_DEPTH, default 4, the fetch-buffer depth; it SHALL be a power of two and at least 2.
REQ-003 One clock; reset is synchronous and active-high.
REQ-004 clk  in  1  core clock; all state updates on the rising edge.
REQ-005 rst  in  1  synchronous active-high reset.
REQ-006 imem_req  out  1  fetch request valid.
REQ-007 imem_addr  out  XLEN  fetch address, word aligned.
REQ-008 imem_gnt  in  1  request accepted this cycle (qualified by imem_req).
REQ-009 imem_rvalid  in  1  read data valid; responses return in order, latency of 1 or more cycles.
REQ-010 imem_rdata  in  INSTR_LEN  instruction word.
REQ-011 pipe_stall  in  1  decode holds; the IFU SHALL not advance its output.
REQ-012 pipe_flush  in  1  redirect; discard all fetched and in-flight instructions.
REQ-013 redirect_pc  in  XLEN  new fetch PC, sampled only when pipe_flush=1.
REQ-014 instr  out  INSTR_LEN  instruction to decode.
REQ-015 instr_valid  out  1  instr/instr_tag valid.
REQ-016 instr_tag  out  XLEN  PC of instr.

Function
REQ-017 fetch_pc SHALL drive imem_addr, and SHALL advance by 4 on each cycle with imem_req&imem_gnt.
REQ-018 imem_req SHALL be 1 only when outstanding+occupancy < FB_DEPTH, pipe_flush=0 and rst=0. Here outstanding is the number of granted requests without a response, and occupancy is the number of buffer entries.
REQ-019 Counters outstanding and occupancy SHALL be $clog2(FB_DEPTH)+1 bits wide, and SHALL never exceed FB_DEPTH.
REQ-020 resp_pc SHALL advance by 4 on each accepted (non-dropped) response. Each response SHALL be pushed into the buffer as the pair {imem_rdata, resp_pc}.
REQ-021 instr, instr_tag and instr_valid SHALL come from the buffer head, with instr_valid=(occupancy!=0)&~pipe_flush.
REQ-022 The buffer SHALL pop when instr_valid & ~pipe_stall.
REQ-023 Push and pop in the same cycle SHALL leave occupancy unchanged. By REQ-018 a push SHALL never find the buffer full; overflow is a design error.
REQ-024 Latency SHALL be: a response accepted in cycle N is visible on instr_valid in cycle N+1, provided it is the head entry.
REQ-025 Throughput SHALL be 1 instr/cycle sustained with 1-cycle memory latency and pipe_stall=0.
REQ-026 On pipe_flush, the following SHALL happen at the next edge:
  - fetch_pc<=redirect_pc and resp_pc<=redirect_pc;
  - occupancy<=0;
  - drop_cnt<=outstanding minus any response arriving in the flush cycle;
  - outstanding<=0.
REQ-027 While drop_cnt!=0, each imem_rvalid SHALL decrement drop_cnt and SHALL not be pushed. Any imem_rvalid in the flush cycle itself SHALL also be discarded.
REQ-028 New requests after a flush MAY issue while drop_cnt!=0. drop_cnt SHALL count against the FB_DEPTH credit.
REQ-029 pipe_flush SHALL take priority over pipe_stall. Flush with stall SHALL clear the buffer.
REQ-030 Back-to-back flushes SHALL each take the latest redirect_pc, and drop counts SHALL accumulate correctly.

Reset
REQ-031 On rst, the following SHALL be set:
  - fetch_pc=resp_pc=RESET_VECTOR;
  - occupancy=outstanding=drop_cnt=0;
  - imem_req=0, instr_valid=0.
  - instr and instr_tag hold don't-care values.
REQ-032 Reset mid-operation SHALL abandon in-flight requests without drop accounting. The instruction memory SHALL share rst.
REQ-033 The first imem_req SHALL assert in the cycle after rst deasserts, with imem_addr=RESET_VECTOR.

Structure
REQ-034 XLEN, INSTR_LEN and the default RESET_VECTOR SHALL live in the shared global package. Any fetch-buffer entry typedef {instr, tag} SHALL live in the shared types package.
REQ-035 The buffer SHALL be one sub-module, fifo_sync, parameterised on width and depth, with push/pop/clear/empty/full/count.
REQ-036 The total RTL SHALL be 120-400 lines.

Verification
REQ-037 Reset release with memory gnt=1 and latency 1: addr 0x0,0x4,0x8 appear on consecutive cycles; instr_valid rises at cycle 2 with tag 0x0, then 1/cycle.
REQ-038 pipe_stall held 5 cycles with a full buffer: imem_req=0, occupancy=4, instr/tag unchanged; on release, 4 pops in order.
REQ-039 Latency-3 memory, 3 outstanding, flush to 0x100: the 3 stale responses are dropped; first instr_valid carries tag 0x100 with data from addr 0x100.
REQ-040 Flush with a response arriving in the same cycle: that response is dropped and drop_cnt counts exactly the remainder.
REQ-041 Two flushes in consecutive cycles (0x200, then 0x300): fetch resumes at 0x300, and no 0x200 instruction reaches instr_valid.
REQ-042 rst asserted mid-stream with 2 outstanding: all outputs return to reset values next cycle, and fetch restarts at RESET_VECTOR.

Source files
------------

// File: rtl/ifu_pkg.sv
// ifu_pkg: shared constants and types for the instruction fetch unit.
//   XLEN                 - address / PC width
//   INSTR_LEN            - instruction word width
//   RESET_VECTOR_DEFAULT - default first fetch address after reset
//   PC_STEP              - PC increment per word-aligned fetch
//   fb_entry_t           - fetch-buffer entry {instr, tag}
package ifu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned INSTR_LEN = 32;

  localparam logic [XLEN-1:0] RESET_VECTOR_DEFAULT = 32'h0000_0000;
  localparam logic [XLEN-1:0] PC_STEP              = XLEN'(4);

  typedef struct packed {
    logic [INSTR_LEN-1:0] instr;
    logic [XLEN-1:0]      tag;
  } fb_entry_t;

endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction-memory request/response bus between the IFU and memory.
//   imem_req    - fetch request valid              (IFU -> mem)
//   imem_addr   - word-aligned fetch address       (IFU -> mem)
//   imem_gnt    - request accepted this cycle      (mem -> IFU)
//   imem_rvalid - in-order read data valid         (mem -> IFU)
//   imem_rdata  - instruction word                 (mem -> IFU)
// master: IFU side; slave: memory side.
interface ifu_if;
  import ifu_pkg::*;

  logic                 imem_req;
  logic [XLEN-1:0]      imem_addr;
  logic                 imem_gnt;
  logic                 imem_rvalid;
  logic [INSTR_LEN-1:0] imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_gnt,
    input  imem_rvalid,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_gnt,
    output imem_rvalid,
    output imem_rdata
  );

endinterface

// File: rtl/ifu_fifo_sync.sv
// fifo_sync: single-clock FIFO, power-of-two depth, synchronous reset.
//   clk, rst     - clock, synchronous active-high reset
//   clear        - synchronous flush of all entries (same effect as rst)
//   push, wdata  - write an entry (ignored when full unless popping too)
//   pop          - discard head entry (ignored when empty)
//   rdata        - head entry (don't-care when empty)
//   empty, full  - status flags
//   count        - number of stored entries, 0..DEPTH
module fifo_sync #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   empty,
  output logic                   full,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem[rptr];

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + AW'(1);
      if (do_pop)  rptr <= rptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage carries no reset; entries are only read when count says valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/ifu.sv
// ifu: instruction fetch unit with credit-limited prefetch into a fetch buffer.
//   clk, rst     - clock, synchronous active-high reset (shared with memory)
//   imem         - ifu_if.master instruction-memory bus
//   pipe_stall   - decode holds; head entry is not popped
//   pipe_flush   - redirect; discards buffered and in-flight instructions
//   redirect_pc  - new fetch PC, used when pipe_flush=1
//   instr        - instruction at buffer head
//   instr_valid  - instr/instr_tag valid
//   instr_tag    - PC of instr
module ifu
  import ifu_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VECTOR = RESET_VECTOR_DEFAULT,
  parameter int unsigned     FB_DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  ifu_if.master                imem,
  input  logic                 pipe_stall,
  input  logic                 pipe_flush,
  input  logic [XLEN-1:0]      redirect_pc,
  output logic [INSTR_LEN-1:0] instr,
  output logic                 instr_valid,
  output logic [XLEN-1:0]      instr_tag
);

  localparam int unsigned CW = $clog2(FB_DEPTH) + 1;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   occupancy;
  logic [CW-1:0]   drop_cnt;
  logic [CW+1:0]   credit_used;

  logic            grant;
  logic            rsp_live;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic            fb_empty;
  logic            fb_full;
  fb_entry_t       fb_wdata;
  fb_entry_t       fb_rdata;

  // Stale responses still owed after a flush occupy credit just like live
  // ones, so the buffer can never be oversubscribed.
  assign credit_used = (CW+2)'(outstanding) + (CW+2)'(occupancy) + (CW+2)'(drop_cnt);

  assign imem.imem_req  = ~rst & ~pipe_flush & (credit_used < (CW+2)'(FB_DEPTH));
  assign imem.imem_addr = fetch_pc;
  assign grant          = imem.imem_req & imem.imem_gnt;

  // Responses return in order, so while drop_cnt is nonzero the arriving
  // response is always one of the stale ones.
  assign rsp_drop = imem.imem_rvalid & (drop_cnt != '0);
  assign rsp_live = imem.imem_rvalid & (drop_cnt == '0);
  assign push     = rsp_live & ~pipe_flush;

  assign instr_valid = ~fb_empty & ~pipe_flush;
  assign pop         = instr_valid & ~pipe_stall;

  assign fb_wdata  = '{instr: imem.imem_rdata, tag: resp_pc};
  assign instr     = fb_rdata.instr;
  assign instr_tag = fb_rdata.tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc    <= RESET_VECTOR;
      resp_pc     <= RESET_VECTOR;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else if (pipe_flush) begin
      fetch_pc    <= redirect_pc;
      resp_pc     <= redirect_pc;
      // Everything in flight becomes stale; a response arriving now retires
      // one of them immediately (from the drop set or the live set alike).
      drop_cnt    <= drop_cnt + outstanding - CW'(imem.imem_rvalid);
      outstanding <= '0;
    end else begin
      if (grant) fetch_pc <= fetch_pc + PC_STEP;
      if (push)  resp_pc  <= resp_pc + PC_STEP;
      outstanding <= outstanding + CW'(grant) - CW'(rsp_live);
      if (rsp_drop) drop_cnt <= drop_cnt - CW'(1);
    end
  end

  fifo_sync #(
    .WIDTH($bits(fb_entry_t)),
    .DEPTH(FB_DEPTH)
  ) u_fb (
    .clk   (clk),
    .rst   (rst),
    .clear (pipe_flush),
    .push  (push),
    .pop   (pop),
    .wdata (fb_wdata),
    .rdata (fb_rdata),
    .empty (fb_empty),
    .full  (fb_full),
    .count (occupancy)
  );

  // The credit check guarantees a slot for every response.
  a_no_overflow : assert property (@(posedge clk) disable iff (rst)
    !(push && fb_full && !pop));

endmodule

// File: tb/tb_ifu.sv
`timescale 1ns/1ps
module tb_ifu;
  import ifu_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 pipe_stall = 1'b0;
  logic                 pipe_flush = 1'b0;
  logic [XLEN-1:0]      redirect_pc = '0;
  logic [INSTR_LEN-1:0] instr;
  logic                 instr_valid;
  logic [XLEN-1:0]      instr_tag;

  ifu_if imem();

  ifu #(
    .RESET_VECTOR(32'h0000_0000),
    .FB_DEPTH(4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem),
    .pipe_stall  (pipe_stall),
    .pipe_flush  (pipe_flush),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_tag   (instr_tag)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Memory model: fixed latency, in-order, cleared by the shared reset.
  typedef struct {
    logic [XLEN-1:0] addr;
    int              due;
  } pend_t;

  pend_t           pend[$];
  int              mem_cyc = 0;
  int              mem_lat = 1;
  logic            mem_gnt = 1'b1;
  logic [XLEN-1:0] sb[$];

  assign imem.imem_gnt = mem_gnt;

  function automatic logic [INSTR_LEN-1:0] mem_data(input logic [XLEN-1:0] a);
    return {a[15:0] ^ 16'hC3A5, ~a[15:0]};
  endfunction

  initial begin
    pend_t p;
    imem.imem_rvalid = 1'b0;
    imem.imem_rdata  = '0;
    forever begin
      @(negedge clk);
      mem_cyc++;
      imem.imem_rvalid = 1'b0;
      if (rst) begin
        pend.delete();
      end else begin
        if (pend.size() != 0 && pend[0].due <= mem_cyc) begin
          p = pend.pop_front();
          imem.imem_rvalid = 1'b1;
          imem.imem_rdata  = mem_data(p.addr);
        end
        if (imem.imem_req && imem.imem_gnt)
          pend.push_back('{addr: imem.imem_addr, due: mem_cyc + mem_lat});
      end
    end
  end

  task automatic do_reset(input int lat);
    @(posedge clk); #1;
    rst = 1'b1; pipe_flush = 1'b0; pipe_stall = 1'b0; mem_gnt = 1'b1; mem_lat = lat;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic test_reset();
    logic [XLEN-1:0] exp_pc;
    int pops = 0;
    @(posedge clk); #1;
    rst = 1'b1; pipe_flush = 1'b0; pipe_stall = 1'b0; mem_gnt = 1'b1; mem_lat = 1;
    @(posedge clk);
    @(negedge clk);
    checks++;
    if (imem.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b required 0", imem.imem_req); end
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b required 0", instr_valid); end
    checks++;
    if (imem.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h required 00000000", imem.imem_addr); end
    checks++;
    if (dut.occupancy !== 3'd0 || dut.outstanding !== 3'd0 || dut.drop_cnt !== 3'd0) begin
      errors++; $display("FAIL reset_counters: got occ=%0d out=%0d drop=%0d required 0/0/0", dut.occupancy, dut.outstanding, dut.drop_cnt);
    end
    @(posedge clk); #1 rst = 1'b0;
    sb.delete();
    for (int k = 0; k < 64; k++) sb.push_back(XLEN'(4 * k));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (i < 3) begin
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== XLEN'(4 * i)) begin
          errors++; $display("FAIL first_fetch c%0d: got req=%b addr=%h required req=1 addr=%h", i, imem.imem_req, imem.imem_addr, 4 * i);
        end
      end
      checks++;
      if (instr_valid !== (i >= 2)) begin
        errors++; $display("FAIL valid_timing c%0d: got %b required %b", i, instr_valid, i >= 2);
      end
      if (instr_valid && !pipe_stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL reset_stream: got tag=%h required no instr", instr_tag); end
        else begin
          exp_pc = sb.pop_front(); pops++;
          if (instr_tag !== exp_pc || instr !== mem_data(exp_pc)) begin
            errors++; $display("FAIL reset_stream: got tag=%h instr=%h required tag=%h instr=%h", instr_tag, instr, exp_pc, mem_data(exp_pc));
          end
        end
      end
      @(posedge clk); #1;
    end
    checks++;
    if (pops != 14) begin errors++; $display("FAIL throughput: got %0d pops required 14", pops); end
  endtask

  task automatic test_stall();
    logic [XLEN-1:0] exp_pc;
    int pops = 0;
    do_reset(1);
    for (int k = 0; k < 64; k++) sb.push_back(XLEN'(4 * k));
    for (int i = 0; i < 21; i++) begin
      pipe_stall = (i < 11);
      @(negedge clk);
      if (i >= 6 && i <= 10) begin
        checks++;
        if (imem.imem_req !== 1'b0 || instr_valid !== 1'b1 || instr_tag !== 32'h0 ||
            instr !== mem_data(32'h0) || dut.occupancy !== 3'd4) begin
          errors++; $display("FAIL stall_hold c%0d: got req=%b valid=%b tag=%h instr=%h occ=%0d required req=0 valid=1 tag=0 instr=%h occ=4",
                             i, imem.imem_req, instr_valid, instr_tag, instr, dut.occupancy, mem_data(32'h0));
        end
      end
      if (i >= 11 && i <= 14) begin
        checks++;
        if (instr_valid !== 1'b1 || instr_tag !== XLEN'(4 * (i - 11))) begin
          errors++; $display("FAIL stall_release c%0d: got valid=%b tag=%h required valid=1 tag=%h", i, instr_valid, instr_tag, 4 * (i - 11));
        end
      end
      if (instr_valid && !pipe_stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL stall_stream: got tag=%h required no instr", instr_tag); end
        else begin
          exp_pc = sb.pop_front(); pops++;
          if (instr_tag !== exp_pc || instr !== mem_data(exp_pc)) begin
            errors++; $display("FAIL stall_stream: got tag=%h instr=%h required tag=%h instr=%h", instr_tag, instr, exp_pc, mem_data(exp_pc));
          end
        end
      end
      @(posedge clk); #1;
    end
    pipe_stall = 1'b0;
    checks++;
    if (pops < 8) begin errors++; $display("FAIL stall_pops: got %0d required at least 8", pops); end
  endtask

  // Flush at cycle 3; the caller's latency decides whether a response
  // lands in the flush cycle itself.
  task automatic test_flush(input string name, input int lat, input logic [XLEN-1:0] target,
                            input logic [2:0] exp_drop);
    logic [XLEN-1:0] exp_pc;
    int pops = 0;
    do_reset(lat);
    for (int k = 0; k < 64; k++) sb.push_back(target + XLEN'(4 * k));
    for (int i = 0; i < 26; i++) begin
      pipe_flush  = (i == 3);
      redirect_pc = target;
      @(negedge clk);
      if (i >= 3 && i <= lat + 4) begin
        checks++;
        if (instr_valid !== 1'b0) begin errors++; $display("FAIL %s_quiet c%0d: got valid=%b tag=%h required valid=0", name, i, instr_valid, instr_tag); end
      end
      if (i == 4) begin
        checks++;
        if (dut.drop_cnt !== exp_drop) begin errors++; $display("FAIL %s_drop_cnt: got %0d required %0d", name, dut.drop_cnt, exp_drop); end
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== target) begin
          errors++; $display("FAIL %s_refetch: got req=%b addr=%h required req=1 addr=%h", name, imem.imem_req, imem.imem_addr, target);
        end
      end
      if (i == lat + 5) begin
        checks++;
        if (instr_valid !== 1'b1) begin errors++; $display("FAIL %s_latency: got valid=%b required 1", name, instr_valid); end
      end
      if (instr_valid && !pipe_stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL %s_stream: got tag=%h required no instr", name, instr_tag); end
        else begin
          exp_pc = sb.pop_front(); pops++;
          if (instr_tag !== exp_pc || instr !== mem_data(exp_pc)) begin
            errors++; $display("FAIL %s_stream: got tag=%h instr=%h required tag=%h instr=%h", name, instr_tag, instr, exp_pc, mem_data(exp_pc));
          end
        end
      end
      @(posedge clk); #1;
    end
    pipe_flush = 1'b0;
    checks++;
    if (pops < 6) begin errors++; $display("FAIL %s_pops: got %0d required at least 6", name, pops); end
  endtask

  task automatic test_back_to_back();
    logic [XLEN-1:0] exp_pc;
    int pops = 0;
    do_reset(3);
    for (int k = 0; k < 64; k++) sb.push_back(32'h300 + XLEN'(4 * k));
    for (int i = 0; i < 26; i++) begin
      pipe_flush  = (i == 3 || i == 4);
      redirect_pc = (i == 3) ? 32'h200 : 32'h300;
      @(negedge clk);
      checks++;
      if (imem.imem_req === 1'b1 && imem.imem_addr[XLEN-1:8] === 24'h2) begin
        errors++; $display("FAIL b2b_no_200_fetch c%0d: got req addr=%h required none in 0x2xx", i, imem.imem_addr);
      end
      if (i == 5) begin
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h300) begin
          errors++; $display("FAIL b2b_refetch: got req=%b addr=%h required req=1 addr=00000300", imem.imem_req, imem.imem_addr);
        end
        checks++;
        if (dut.drop_cnt !== 3'd1) begin errors++; $display("FAIL b2b_drop_cnt: got %0d required 1", dut.drop_cnt); end
      end
      if (instr_valid && !pipe_stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL b2b_stream: got tag=%h required no instr", instr_tag); end
        else begin
          exp_pc = sb.pop_front(); pops++;
          if (instr_tag !== exp_pc || instr !== mem_data(exp_pc)) begin
            errors++; $display("FAIL b2b_stream: got tag=%h instr=%h required tag=%h instr=%h", instr_tag, instr, exp_pc, mem_data(exp_pc));
          end
        end
      end
      @(posedge clk); #1;
    end
    pipe_flush = 1'b0;
    checks++;
    if (pops < 6) begin errors++; $display("FAIL b2b_pops: got %0d required at least 6", pops); end
  endtask

  task automatic test_reset_mid();
    logic [XLEN-1:0] exp_pc;
    int pops = 0;
    do_reset(2);
    for (int k = 0; k < 64; k++) sb.push_back(XLEN'(4 * k));
    for (int i = 0; i < 24; i++) begin
      rst = (i == 6 || i == 7);
      if (i == 8) begin
        sb.delete();
        for (int k = 0; k < 64; k++) sb.push_back(XLEN'(4 * k));
      end
      @(negedge clk);
      if (i == 6) begin
        checks++;
        if (dut.outstanding !== 3'd2) begin errors++; $display("FAIL mid_precond: got outstanding=%0d required 2", dut.outstanding); end
      end
      if (i == 7) begin
        checks++;
        if (imem.imem_req !== 1'b0 || instr_valid !== 1'b0 || imem.imem_addr !== 32'h0) begin
          errors++; $display("FAIL mid_reset_outputs: got req=%b valid=%b addr=%h required 0/0/00000000", imem.imem_req, instr_valid, imem.imem_addr);
        end
        checks++;
        if (dut.drop_cnt !== 3'd0 || dut.outstanding !== 3'd0 || dut.occupancy !== 3'd0) begin
          errors++; $display("FAIL mid_reset_counters: got drop=%0d out=%0d occ=%0d required 0/0/0", dut.drop_cnt, dut.outstanding, dut.occupancy);
        end
      end
      if (i == 8) begin
        checks++;
        if (imem.imem_req !== 1'b1 || imem.imem_addr !== 32'h0) begin
          errors++; $display("FAIL mid_restart: got req=%b addr=%h required req=1 addr=00000000", imem.imem_req, imem.imem_addr);
        end
      end
      if (!rst && instr_valid && !pipe_stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL mid_stream: got tag=%h required no instr", instr_tag); end
        else begin
          exp_pc = sb.pop_front(); pops++;
          if (instr_tag !== exp_pc || instr !== mem_data(exp_pc)) begin
            errors++; $display("FAIL mid_stream c%0d: got tag=%h instr=%h required tag=%h instr=%h", i, instr_tag, instr, exp_pc, mem_data(exp_pc));
          end
        end
      end
      @(posedge clk); #1;
    end
    rst = 1'b0;
    checks++;
    if (pops < 14) begin errors++; $display("FAIL mid_pops: got %0d required at least 14", pops); end
  endtask

  task automatic test_random();
    logic [XLEN-1:0] exp_pc;
    int pops = 0;
    do_reset(2);
    for (int k = 0; k < 256; k++) sb.push_back(XLEN'(4 * k));
    for (int i = 0; i < 160; i++) begin
      pipe_stall = ($urandom_range(0, 3) == 0);
      mem_gnt    = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checks++;
      if (dut.occupancy > 3'd4 || dut.outstanding > 3'd4) begin
        errors++; $display("FAIL rand_bounds: got occ=%0d out=%0d required both <= 4", dut.occupancy, dut.outstanding);
      end
      if (instr_valid && !pipe_stall) begin
        checks++;
        if (sb.size() == 0) begin errors++; $display("FAIL rand_stream: got tag=%h required no instr", instr_tag); end
        else begin
          exp_pc = sb.pop_front(); pops++;
          if (instr_tag !== exp_pc || instr !== mem_data(exp_pc)) begin
            errors++; $display("FAIL rand_stream: got tag=%h instr=%h required tag=%h instr=%h", instr_tag, instr, exp_pc, mem_data(exp_pc));
          end
        end
      end
      @(posedge clk); #1;
    end
    pipe_stall = 1'b0;
    mem_gnt    = 1'b1;
    checks++;
    if (pops < 40) begin errors++; $display("FAIL rand_pops: got %0d required at least 40", pops); end
  endtask

  initial begin
    test_reset();
    test_stall();
    test_flush("flush_overlap", 3, 32'h100, 3'd2);
    test_flush("flush_clean", 4, 32'h180, 3'd3);
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: got no completion required finish before 2ms");
    $fatal(1, "timeout");
  end

endmodule
